// File: rtl/l1_cache_ctrl_pkg.sv
// Shared definitions for the L1 data cache controller: bus command encodings
// (common with the bus arbiter), width defaults and FSM state encodings.
package l1_cache_ctrl_pkg;

    localparam int IOSTATE_W  = 2;
    localparam int WORD_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [IOSTATE_W-1:0] {
        IO_IDLE = 2'b00,
        IO_RD   = 2'b01,
        IO_WT   = 2'b10
    } iostate_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
    } cache_state_e;

endpackage

// File: rtl/l1_cache_ctrl_if.sv
// Processor request/ready handshake and memory bus command signals of one
// cache instance; slave = cache controller, master = core/bus side.
interface l1_cache_ctrl_if
    import l1_cache_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_W-1:0]    cpu_wdata;
    logic [WORD_W-1:0]    cpu_rdata;
    logic                 cpu_ready;

    logic [IOSTATE_W-1:0] bus_rw;
    logic [ADDR_W-1:0]    bus_addr;
    logic [WORD_W-1:0]    bus_wdata;
    logic [WORD_W-1:0]    bus_rdata;
    logic                 bus_rd_en;
    logic                 bus_wb_done;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output bus_rw, bus_addr, bus_wdata,
        input  bus_rdata, bus_rd_en, bus_wb_done
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  bus_rw, bus_addr, bus_wdata,
        output bus_rdata, bus_rd_en, bus_wb_done
    );

endinterface

// File: rtl/l1_cache_ctrl_cache_tag_array.sv
// Per-line valid/dirty/tag/data storage: one combinational read port, one
// full-line write port, synchronous clear on reset.
module cache_tag_array #(
    parameter int TAG_W   = 6,
    parameter int WORD_W  = 32,
    parameter int INDEX_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [WORD_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [WORD_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic              valid_q [LINES];
    logic              dirty_q [LINES];
    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [WORD_W-1:0] data_q  [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
            tag_q[wr_index]   <= wr_tag;
            data_q[wr_index]  <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller, one-word lines.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | waiting for a processor request; latches addr/we/wdata
// LOOKUP    | one cycle tag compare, picks hit / writeback / refill
// WRITEBACK | bus WT of the dirty victim until bus_wb_done
// REFILL    | bus RD of the requested word until bus_rd_en
// RESPOND   | one cycle: load data out or store into the line
module l1_cache_ctrl
    import l1_cache_ctrl_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INDEX_W = 2
) (
    input  logic clk,
    input  logic reset,
    l1_cache_ctrl_if.slave cif
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    cache_state_e         state, state_n;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_we;
    logic [WORD_W-1:0]    req_wdata;
    logic                 cpu_ready_q;
    logic [WORD_W-1:0]    cpu_rdata_q;
    logic [ADDR_W-1:0]    bus_addr_q;
    logic [WORD_W-1:0]    bus_wdata_q;
    logic [IOSTATE_W-1:0] bus_rw_c;

    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic                 rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]     rd_tag;
    logic [WORD_W-1:0]    rd_data;
    logic                 wr_en, wr_valid, wr_dirty;
    logic [TAG_W-1:0]     wr_tag;
    logic [WORD_W-1:0]    wr_data;

    assign req_index = req_addr[INDEX_W-1:0];
    assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
    assign hit       = rd_valid && (rd_tag == req_tag);

    cache_tag_array #(
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W),
        .INDEX_W (INDEX_W)
    ) u_tag_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (req_index),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        wr_valid = rd_valid;
        wr_dirty = rd_dirty;
        wr_tag   = rd_tag;
        wr_data  = rd_data;
        bus_rw_c = IO_IDLE;
        case (state)
            S_IDLE: begin
                if (cif.cpu_req && !cpu_ready_q) state_n = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit)                       state_n = S_RESPOND;
                else if (rd_valid && rd_dirty) state_n = S_WRITEBACK;
                else                           state_n = S_REFILL;
            end
            S_WRITEBACK: begin
                bus_rw_c = IO_WT;
                if (cif.bus_wb_done) begin
                    wr_en    = 1'b1;
                    wr_dirty = 1'b0;
                    state_n  = S_REFILL;
                end
            end
            S_REFILL: begin
                bus_rw_c = IO_RD;
                if (cif.bus_rd_en) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b0;
                    wr_tag   = req_tag;
                    wr_data  = cif.bus_rdata;
                    state_n  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (req_we) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b1;
                    wr_data  = req_wdata;
                end
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // The arbiter resamples the command right after done; drop it now
        // so it never sees a second transaction.
        if (cif.bus_wb_done) bus_rw_c = IO_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr    <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            cpu_ready_q <= (state == S_RESPOND);
            if (state == S_IDLE && cif.cpu_req && !cpu_ready_q) begin
                req_addr  <= cif.cpu_addr;
                req_we    <= cif.cpu_we;
                req_wdata <= cif.cpu_wdata;
            end
            if (state == S_LOOKUP && !hit) begin
                if (rd_valid && rd_dirty) begin
                    bus_addr_q  <= {rd_tag, req_index};
                    bus_wdata_q <= rd_data;
                end else begin
                    bus_addr_q  <= req_addr;
                end
            end
            if (state == S_WRITEBACK && cif.bus_wb_done) bus_addr_q <= req_addr;
            if (state == S_RESPOND && !req_we) cpu_rdata_q <= rd_data;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
            if (!hit && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

    assign cif.cpu_ready = cpu_ready_q;
    assign cif.cpu_rdata = cpu_rdata_q;
    assign cif.bus_rw    = bus_rw_c;
    assign cif.bus_addr  = bus_addr_q;
    assign cif.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed bench for l1_cache_ctrl with a small bus responder that logs
// every completed transaction.
module tb_l1_cache_ctrl;
    import l1_cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l1_cache_ctrl_if #(.WORD_W(32), .ADDR_W(8)) cif ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    l1_cache_ctrl #(.WORD_W(32), .ADDR_W(8), .INDEX_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif.slave)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // bus responder
    int          bus_lat = 2;
    logic [31:0] next_rdata = '0;
    int          rd_cnt = 0, wt_cnt = 0, n_log = 0;
    logic [1:0]  log_cmd [16];
    logic [7:0]  last_rd_addr = '0, last_wt_addr = '0;
    logic [31:0] last_wt_data = '0;
    logic [7:0]  start_addr = '0;
    int          lat_cnt = 0;

    initial begin
        cif.bus_rdata   = '0;
        cif.bus_rd_en   = 1'b0;
        cif.bus_wb_done = 1'b0;
    end

    always @(negedge clk) begin
        if (cif.bus_wb_done) begin
            cif.bus_wb_done = 1'b0;
            cif.bus_rd_en   = 1'b0;
            lat_cnt = 0;
        end else if (cif.bus_rw != IO_IDLE) begin
            if (lat_cnt == 0) start_addr = cif.bus_addr;
            lat_cnt++;
            if (lat_cnt >= bus_lat) begin
                check_val("addr_stable", 32'(cif.bus_addr), 32'(start_addr));
                if (n_log < 16) log_cmd[n_log] = cif.bus_rw;
                n_log++;
                if (cif.bus_rw == IO_RD) begin
                    rd_cnt++;
                    last_rd_addr  = cif.bus_addr;
                    cif.bus_rdata = next_rdata;
                    cif.bus_rd_en = 1'b1;
                end else begin
                    wt_cnt++;
                    last_wt_addr = cif.bus_addr;
                    last_wt_data = cif.bus_wdata;
                end
                cif.bus_wb_done = 1'b1;
                #1 check_val("rw_masked_on_done", 32'(cif.bus_rw), 32'(IO_IDLE));
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        bit got = 0;
        @(negedge clk);
        cif.cpu_req   = 1'b1;
        cif.cpu_we    = we;
        cif.cpu_addr  = addr;
        cif.cpu_wdata = wdata;
        lat = 0;
        rdata = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cif.cpu_ready) begin
                got = 1;
                rdata = cif.cpu_rdata;
                cif.cpu_req = 1'b0;
            end
        end
        if (!got) begin
            check_val("ready_timeout", 32'(cif.cpu_ready), 32'd1);
            cif.cpu_req = 1'b0;
        end
        @(posedge clk);
        #1 check_val("ready_single_pulse", 32'(cif.cpu_ready), 32'd0);
    endtask

    logic [31:0] rd;
    int lat;
    int rd0, wt0;

    initial begin
        cif.cpu_req   = 1'b0;
        cif.cpu_we    = 1'b0;
        cif.cpu_addr  = '0;
        cif.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(cif.cpu_ready), 32'd0);
        check_val("rst_rdata", cif.cpu_rdata, 32'd0);
        check_val("rst_bus_rw", 32'(cif.bus_rw), 32'(IO_IDLE));
        check_val("rst_bus_addr", 32'(cif.bus_addr), 32'd0);
        check_val("rst_bus_wdata", cif.bus_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // cold miss: one RD of 0x05, no WT
        next_rdata = 32'h1234;
        access(1'b0, 8'h05, '0, rd, lat);
        check_val("miss_rdata", rd, 32'h1234);
        check_val("miss_rd_cnt", 32'(rd_cnt), 32'd1);
        check_val("miss_wt_cnt", 32'(wt_cnt), 32'd0);
        check_val("miss_rd_addr", 32'(last_rd_addr), 32'h05);

        // hit
        access(1'b0, 8'h05, '0, rd, lat);
        check_val("hit_rdata", rd, 32'h1234);
        check_val("hit_latency", 32'(lat), 32'd3);
        check_val("hit_no_bus", 32'(n_log), 32'd1);

        // store hit
        access(1'b1, 8'h05, 32'hAAAA, rd, lat);
        check_val("store_latency", 32'(lat), 32'd3);
        check_val("store_no_bus", 32'(n_log), 32'd1);

        // conflict miss with dirty victim: WT 0xAAAA to 0x05 then RD 0x09
        next_rdata = 32'h5678;
        bus_lat = 3;
        access(1'b0, 8'h09, '0, rd, lat);
        check_val("evict_rdata", rd, 32'h5678);
        check_val("evict_wt_cnt", 32'(wt_cnt), 32'd1);
        check_val("evict_rd_cnt", 32'(rd_cnt), 32'd2);
        check_val("evict_wt_addr", 32'(last_wt_addr), 32'h05);
        check_val("evict_wt_data", last_wt_data, 32'hAAAA);
        check_val("evict_rd_addr", 32'(last_rd_addr), 32'h09);
        check_val("evict_order_wt", 32'(log_cmd[1]), 32'(IO_WT));
        check_val("evict_order_rd", 32'(log_cmd[2]), 32'(IO_RD));

        // clean victim: RD only
        next_rdata = 32'hAAAA;
        bus_lat = 1;
        access(1'b0, 8'h05, '0, rd, lat);
        check_val("clean_rdata", rd, 32'hAAAA);
        check_val("clean_wt_cnt", 32'(wt_cnt), 32'd1);
        check_val("clean_rd_cnt", 32'(rd_cnt), 32'd3);

        // reset while in REFILL
        bus_lat = 40;
        @(negedge clk);
        cif.cpu_req  = 1'b1;
        cif.cpu_we   = 1'b0;
        cif.cpu_addr = 8'h0D;
        for (int i = 0; i < 20 && cif.bus_rw != IO_RD; i++) @(negedge clk);
        check_val("reach_refill", 32'(cif.bus_rw), 32'(IO_RD));
        reset = 1'b1;
        cif.cpu_req = 1'b0;
        @(posedge clk);
        #1 check_val("rst_abort_rw", 32'(cif.bus_rw), 32'(IO_IDLE));
        @(negedge clk);
        reset = 1'b0;
        rd0 = rd_cnt;
        wt0 = wt_cnt;

        // previously valid line must miss again
        bus_lat = 2;
        next_rdata = 32'hBEEF;
        access(1'b0, 8'h05, '0, rd, lat);
        check_val("post_rst_rdata", rd, 32'hBEEF);
        check_val("post_rst_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
        check_val("post_rst_wt_cnt", 32'(wt_cnt - wt0), 32'd0);

        access(1'b0, 8'h05, '0, rd, lat);
        check_val("hit2_rdata", rd, 32'hBEEF);
        access(1'b0, 8'h05, '0, rd, lat);
        check_val("hit3_latency", 32'(lat), 32'd3);
        check_val("hit3_no_bus", 32'(rd_cnt - rd0), 32'd1);
`ifdef CACHE_STATS_EN
        check_val("stats_hit", 32'(hit_cnt), 32'd2);
        check_val("stats_miss", 32'(miss_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
